// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous data RAM.
// Supports a bounded ownership lock for read-modify-write and tags read returns to the issuer.
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic              req0_lock,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic              req1_lock,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [8:0] LOCK_LIMIT = 9'(LOCK_MAX);

    logic       last_grant_q, last_grant_d;
    logic       lock_active_q, lock_active_d;
    logic       lock_owner_q, lock_owner_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       rd_pending_q, rd_pending_d;
    logic       rd_tag_q, rd_tag_d;

    logic              winner;
    logic              access;
    logic              win_we;
    logic              win_lock;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // Winner selection; access is gated by reset so every output is quiet in reset.
    always_comb begin
        winner = 1'b0;
        if (lock_active_q && (lock_owner_q ? req1_valid : req0_valid)) begin
            winner = lock_owner_q;
        end else if (lock_active_q) begin
            winner = ~lock_owner_q;
        end else if (req0_valid && req1_valid) begin
            winner = ~last_grant_q;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
        access    = reset && (winner ? req1_valid : req0_valid);
        win_we    = winner ? req1_we    : req0_we;
        win_lock  = winner ? req1_lock  : req0_lock;
        win_addr  = winner ? req1_addr  : req0_addr;
        win_wdata = winner ? req1_wdata : req0_wdata;
    end

    assign req0_ready = access && !winner;
    assign req1_ready = access && winner;
    assign mem_en     = access;
    assign mem_we     = access && win_we;
    assign mem_addr   = access ? win_addr  : '0;
    assign mem_wdata  = access ? win_wdata : '0;

    assign req0_rvalid = reset && rd_pending_q && !rd_tag_q;
    assign req1_rvalid = reset && rd_pending_q && rd_tag_q;
    assign req0_rdata  = req0_rvalid ? mem_rdata : '0;
    assign req1_rdata  = req1_rvalid ? mem_rdata : '0;

    always_comb begin
        last_grant_d  = last_grant_q;
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
        lock_cnt_d    = lock_cnt_q;
        rd_pending_d  = access && !win_we;
        rd_tag_d      = winner;
        if (access) begin
            last_grant_d = winner;
            if (!lock_active_q) begin
                if (win_lock && (LOCK_MAX > 1)) begin
                    lock_active_d = 1'b1;
                    lock_owner_d  = winner;
                    lock_cnt_d    = 8'd1;
                end
            end else if (winner == lock_owner_q) begin
                // Releasing on the access that would hit the limit bounds the hold time.
                if (!win_lock || (({1'b0, lock_cnt_q} + 9'd1) >= LOCK_LIMIT)) begin
                    lock_active_d = 1'b0;
                    lock_cnt_d    = 8'd0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_q  <= 1'b1;
            lock_active_q <= 1'b0;
            lock_owner_q  <= 1'b0;
            lock_cnt_q    <= 8'd0;
            rd_pending_q  <= 1'b0;
            rd_tag_q      <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
            lock_cnt_q    <= lock_cnt_d;
            rd_pending_q  <= rd_pending_d;
            rd_tag_q      <= rd_tag_d;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter for the single-port synchronous data RAM in GroupProject3710.
- Requester 0 is the CPU load/store port; requester 1 is the peripheral port (switch/LED I/O, VGA fetch).
- Round-robin grant with an optional bounded lock, which supports atomic read-modify-write sequences.
- Returns 1-cycle-latency read data to the requester that issued the read.

Parameters:
- ADDR_W, 16, address width in words.
- DATA_W, 16, data width.
- LOCK_MAX, 8, maximum consecutive cycles a locked owner may hold the port before forced release (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req0_valid  in  1  CPU request present
- req0_we  in  1  1 = write, 0 = read
- req0_lock  in  1  request to keep ownership after this access
- req0_addr  in  ADDR_W  CPU address
- req0_wdata  in  DATA_W  CPU write data
- req0_ready  out  1  CPU request accepted this cycle (combinational)
- req0_rvalid  out  1  CPU read data valid
- req0_rdata  out  DATA_W  CPU read data
- req1_valid, req1_we, req1_lock, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata: same as req0_*, for the peripheral port
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read strobe

Behaviour:
- Reset (reset==0 at a clk edge) clears all state:
  - last_grant=1, so requester 0 wins the first tie.
  - lock_owner=none, lock_cnt=0, rd_pending=0, rd_tag=0.
  - All outputs are 0 while reset is held.
- Arbitration is combinational each cycle:
  - If a lock is active and the owner's valid=1, the owner wins.
  - If a lock is active and the owner's valid=0, the other requester may win; the lock is not released.
  - With no lock: if only one requester is valid, it wins.
  - With no lock and both valid, the requester != last_grant wins.
- reqN_ready=1 only for the winner. An access occurs when valid&&ready.
- On an access, mem_en=1 and mem_we/mem_addr/mem_wdata are muxed from the winner. With no access, mem_en=0 and the other memory outputs are 0.
- On every access, last_grant is updated to the winner.
- Lock counter:
  - An access with lock=1 and no active lock sets lock_owner=winner and lock_cnt=1.
  - Each further owner access with lock=1 increments lock_cnt.
  - An owner access with lock=0 releases the lock.
  - An owner access that would make lock_cnt reach LOCK_MAX releases the lock. That access is still performed, and last_grant = owner, so the other requester wins the next tie.
  - While a lock is active, lock=1 from the non-owner is ignored.
- Read return:
  - An accepted read sets rd_pending=1 and rd_tag=winner for the next cycle.
  - In that next cycle, req{rd_tag}_rvalid=1 and req{rd_tag}_rdata=mem_rdata. The other port's rdata is 0.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating requesters return in issue order, one per cycle, with no bubbles.
- Read-after-write to the same address in consecutive cycles returns the new data; this relies on the RAM ordering, and the arbiter adds no forwarding.
- Reset mid-operation: a pending rvalid is dropped (rvalid=0 in the cycle after reset asserts) and any lock is cleared.
- Throughput: one access per cycle, with no idle cycle on grant switch.

Test Plan:
- Reset, then req0 reads addr 0x00FF holding 0x000D -> req0_ready=1 same cycle; req0_rvalid=1 with rdata=0x000D next cycle; req1_rvalid=0.
- Both valid for 4 cycles, no lock -> grants 0,1,0,1; mem_addr alternates between the two addresses; rvalid tags alternate accordingly.
- req1 write 0x1234 to 0x0010 while req0 is idle, then req0 reads 0x0010 -> req0_rdata=0x1234.
- req0_lock=1 with both valid, LOCK_MAX=3 -> req0 granted 3 consecutive cycles; 4th cycle grants req1.
- req0 locks, then req0_valid drops for one cycle while req1 is valid -> req1 is granted that cycle; req0 regains the grant next cycle when both are valid.
- req1 read accepted, then reset=0 on the next edge -> req1_rvalid stays 0; after release, the first tie goes to req0.
